// File: rtl/pla_control.sv
`default_nettype none
// ============================================================================
//  Module      : pla_control
//  Description : Main control decoder for the multicycle datapath. Maps the
//                6-bit opcode and the 4-bit current FSM state to every
//                datapath control strobe and to the 4-bit next-state code.
//                The decode is purely combinational.
//
//                Optional feature macro: PLA_STATE_REG_EN
//                  defined   - a 4-bit state register is built. It loads the
//                              next-state code on each rising clk edge and
//                              is driven out on State. The integrator ties
//                              State back to CurrentState.
//                  undefined - no sequential logic and no State port. clk
//                              and reset are present but unused.
//
//  Ports       : clk          - clock (used only by the state register)
//                reset        - asynchronous active-high reset (state reg only)
//                Op           - instruction opcode field
//                CurrentState - present FSM state code used by the decode
//                PCWrite .. RegDst - datapath strobes and mux selects
//                NS3..NS0     - next-state code
//                State        - registered state (PLA_STATE_REG_EN only)
//  Revision    : 1.0 - initial release
// ============================================================================
module pla_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [3:0] CurrentState,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       PCSource1,
    output logic       PCSource0,
    output logic       ALUOp1,
    output logic       ALUOp0,
    output logic       ALUSrcB1,
    output logic       ALUSrcB0,
    output logic       ALUSrcBA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       NS3,
    output logic       NS2,
    output logic       NS1,
    output logic       NS0
`ifdef PLA_STATE_REG_EN
    ,
    output logic [3:0] State
`endif
  );

  // State encodings of the multicycle control FSM.
  localparam logic [3:0] ST_FETCH   = 4'd0;
  localparam logic [3:0] ST_DECODE  = 4'd1;
  localparam logic [3:0] ST_ADDR    = 4'd2;
  localparam logic [3:0] ST_MEMRD   = 4'd3;
  localparam logic [3:0] ST_WBLOAD  = 4'd4;
  localparam logic [3:0] ST_MEMWR   = 4'd5;
  localparam logic [3:0] ST_EXEC_R  = 4'd6;
  localparam logic [3:0] ST_R_DONE  = 4'd7;
  localparam logic [3:0] ST_BRANCH  = 4'd8;
  localparam logic [3:0] ST_JUMP    = 4'd9;

  // Opcodes recognised by the dispatch states.
  localparam logic [5:0] OP_LOAD    = 6'b000011;
  localparam logic [5:0] OP_STORE   = 6'b100011;
  localparam logic [5:0] OP_RTYPE   = 6'b110011;
  localparam logic [5:0] OP_BRANCH  = 6'b001011;
  localparam logic [5:0] OP_JUMP_A  = 6'b010111;
  localparam logic [5:0] OP_JUMP_B  = 6'b101111;

  logic [3:0] ns;

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    PCSource1   = 1'b0;
    PCSource0   = 1'b0;
    ALUOp1      = 1'b0;
    ALUOp0      = 1'b0;
    ALUSrcB1    = 1'b0;
    ALUSrcB0    = 1'b0;
    ALUSrcBA    = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    // Unused codes 10-15 fall through to all-zero strobes and fetch.
    ns          = ST_FETCH;

    case (CurrentState)
      ST_FETCH: begin
        PCWrite  = 1'b1;
        MemRead  = 1'b1;
        IRWrite  = 1'b1;
        ALUSrcB0 = 1'b1;
        ns       = ST_DECODE;
      end
      ST_DECODE: begin
        ALUSrcB1 = 1'b1;
        ALUSrcB0 = 1'b1;
        case (Op)
          OP_LOAD, OP_STORE:  ns = ST_ADDR;
          OP_RTYPE:           ns = ST_EXEC_R;
          OP_BRANCH:          ns = ST_BRANCH;
          OP_JUMP_A, OP_JUMP_B: ns = ST_JUMP;
          default:            ns = ST_FETCH;
        endcase
      end
      ST_ADDR: begin
        ALUSrcBA = 1'b1;
        ALUSrcB1 = 1'b1;
        case (Op)
          OP_LOAD:  ns = ST_MEMRD;
          OP_STORE: ns = ST_MEMWR;
          default:  ns = ST_FETCH;
        endcase
      end
      ST_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        ns      = ST_WBLOAD;
      end
      ST_WBLOAD: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      ST_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      ST_EXEC_R: begin
        ALUOp1   = 1'b1;
        ALUSrcBA = 1'b1;
        ns       = ST_R_DONE;
      end
      ST_R_DONE: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      ST_BRANCH: begin
        PCWriteCond = 1'b1;
        PCSource0   = 1'b1;
        ALUOp0      = 1'b1;
        ALUSrcBA    = 1'b1;
      end
      ST_JUMP: begin
        PCWrite   = 1'b1;
        PCSource1 = 1'b1;
      end
      default: ;
    endcase
  end

  assign {NS3, NS2, NS1, NS0} = ns;

`ifdef PLA_STATE_REG_EN
  logic [3:0] state_q;
  logic [3:0] state_d;

  always_comb begin
    state_d = ns;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  assign State = state_q;
`else
  // clk and reset only feed the optional state register.
  logic unused_clk_reset;
  assign unused_clk_reset = clk ^ reset;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pla_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pla_control
//  Description : Directed self-checking bench for pla_control. Each scenario
//                task applies hand-computed vectors and compares the packed
//                strobe vector and next-state code against them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pla_control;

  logic       clk;
  logic       reset;
  logic [5:0] Op;
  logic [3:0] cs_drv;
  logic [3:0] cs_in;
  logic       tie_state;

  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
  logic PCSource1, PCSource0, ALUOp1, ALUOp0, ALUSrcB1, ALUSrcB0, ALUSrcBA;
  logic RegWrite, RegDst, NS3, NS2, NS1, NS0;

  int checks;
  int failures;

`ifdef PLA_STATE_REG_EN
  logic [3:0] State;
  assign cs_in = tie_state ? State : cs_drv;
`else
  assign cs_in = cs_drv;
`endif

  pla_control dut (
    .clk          (clk),
    .reset        (reset),
    .Op           (Op),
    .CurrentState (cs_in),
    .PCWrite      (PCWrite),
    .PCWriteCond  (PCWriteCond),
    .IorD         (IorD),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .IRWrite      (IRWrite),
    .MemtoReg     (MemtoReg),
    .PCSource1    (PCSource1),
    .PCSource0    (PCSource0),
    .ALUOp1       (ALUOp1),
    .ALUOp0       (ALUOp0),
    .ALUSrcB1     (ALUSrcB1),
    .ALUSrcB0     (ALUSrcB0),
    .ALUSrcBA     (ALUSrcBA),
    .RegWrite     (RegWrite),
    .RegDst       (RegDst),
    .NS3          (NS3),
    .NS2          (NS2),
    .NS1          (NS1),
    .NS0          (NS0)
`ifdef PLA_STATE_REG_EN
    ,
    .State        (State)
`endif
  );

  // Strobe order: PCWrite is the MSB, RegDst the LSB.
  logic [15:0] strobes;
  logic [3:0]  ns;
  assign strobes = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                    MemtoReg, PCSource1, PCSource0, ALUOp1, ALUOp0,
                    ALUSrcB1, ALUSrcB0, ALUSrcBA, RegWrite, RegDst};
  assign ns = {NS3, NS2, NS1, NS0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector layout: {op[5:0], state[3:0], strobes[15:0], ns[3:0]}.
  task automatic run_vectors(input string tag, input logic [29:0] v);
    Op     = v[29:24];
    cs_drv = v[23:20];
    #1;
    checks++;
    if (strobes !== v[19:4]) begin
      failures++;
      $display("FAIL %s strobes op=%b st=%0d actual=%h required=%h",
               tag, v[29:24], v[23:20], strobes, v[19:4]);
    end
    checks++;
    if (ns !== v[3:0]) begin
      failures++;
      $display("FAIL %s ns op=%b st=%0d actual=%b required=%b",
               tag, v[29:24], v[23:20], ns, v[3:0]);
    end
  endtask

  task automatic test_reset();
    tie_state = 1'b0;
    reset     = 1'b1;
    Op        = 6'b110111;
    cs_drv    = 4'd0;
    #1;
    // Reset must not disturb the combinational decode.
    checks++;
    if (strobes !== 16'h9408) begin
      failures++;
      $display("FAIL reset_strobes actual=%h required=%h", strobes, 16'h9408);
    end
    checks++;
    if (ns !== 4'b0001) begin
      failures++;
      $display("FAIL reset_ns actual=%b required=%b", ns, 4'b0001);
    end
`ifdef PLA_STATE_REG_EN
    checks++;
    if (State !== 4'd0) begin
      failures++;
      $display("FAIL reset_state actual=%0d required=0", State);
    end
`endif
  endtask

  task automatic test_fetch_rtype_done();
    logic [29:0] tv [2];
    tv = '{{6'b110111, 4'd0, 16'h9408, 4'd1},
           {6'b110111, 4'd7, 16'h0003, 4'd0}};
    foreach (tv[i]) run_vectors("fetch_rdone", tv[i]);
  endtask

  task automatic test_load_store();
    logic [29:0] tv [6];
    tv = '{{6'b100011, 4'd1, 16'h0018, 4'd2},
           {6'b100011, 4'd2, 16'h0014, 4'd5},
           {6'b100011, 4'd5, 16'h2800, 4'd0},
           {6'b000011, 4'd2, 16'h0014, 4'd3},
           {6'b000011, 4'd3, 16'h3000, 4'd4},
           {6'b000011, 4'd4, 16'h0202, 4'd0}};
    foreach (tv[i]) run_vectors("load_store", tv[i]);
  endtask

  task automatic test_rtype_jump();
    logic [29:0] tv [7];
    tv = '{{6'b110011, 4'd1, 16'h0018, 4'd6},
           {6'b110011, 4'd6, 16'h0044, 4'd7},
           {6'b110011, 4'd2, 16'h0014, 4'd0},
           {6'b010111, 4'd1, 16'h0018, 4'd9},
           {6'b101111, 4'd1, 16'h0018, 4'd9},
           {6'b101111, 4'd9, 16'h8100, 4'd0},
           {6'b000000, 4'd9, 16'h8100, 4'd0}};
    foreach (tv[i]) run_vectors("rtype_jump", tv[i]);
  endtask

  task automatic test_branch_default();
    logic [29:0] tv [5];
    tv = '{{6'b001011, 4'd1, 16'h0018, 4'd8},
           {6'b001011, 4'd8, 16'h40A4, 4'd0},
           {6'b000000, 4'd1, 16'h0018, 4'd0},
           {6'b111111, 4'd1, 16'h0018, 4'd0},
           {6'b100111, 4'd1, 16'h0018, 4'd0}};
    foreach (tv[i]) run_vectors("branch_default", tv[i]);
  endtask

  task automatic test_undefined_states();
    logic [5:0] ops [4];
    ops = '{6'b000011, 6'b110011, 6'b001011, 6'b111111};
    for (int s = 10; s < 16; s++) begin
      foreach (ops[k]) begin
        run_vectors("undef_state", {ops[k], 4'(s), 16'h0000, 4'd0});
      end
    end
  endtask

`ifdef PLA_STATE_REG_EN
  task automatic test_state_reg();
    logic [3:0] exp_seq [3];
    exp_seq = '{4'd1, 4'd6, 4'd7};
    Op        = 6'b110011;
    tie_state = 1'b1;
    reset     = 1'b1;
    @(negedge clk);
    checks++;
    if (State !== 4'd0) begin
      failures++;
      $display("FAIL state_held_in_reset actual=%0d required=0", State);
    end
    reset = 1'b0;
    foreach (exp_seq[i]) begin
      @(posedge clk);
      #1;
      checks++;
      if (State !== exp_seq[i]) begin
        failures++;
        $display("FAIL state_step%0d actual=%0d required=%0d",
                 i, State, exp_seq[i]);
      end
    end
    // State now 7; assert reset between edges.
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (State !== 4'd0) begin
      failures++;
      $display("FAIL state_async_reset actual=%0d required=0", State);
    end
    @(posedge clk);
    #1;
    checks++;
    if (State !== 4'd0) begin
      failures++;
      $display("FAIL state_reset_hold actual=%0d required=0", State);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (State !== 4'd1) begin
      failures++;
      $display("FAIL state_after_release actual=%0d required=1", State);
    end
    tie_state = 1'b0;
  endtask
`endif

  initial begin
    checks    = 0;
    failures  = 0;
    tie_state = 1'b0;
    reset     = 1'b1;
    Op        = 6'd0;
    cs_drv    = 4'd0;
    test_reset();
    test_fetch_rtype_done();
    test_load_store();
    test_rtype_jump();
    test_branch_default();
    test_undefined_states();
`ifdef PLA_STATE_REG_EN
    test_state_reg();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
